score_display_driver: RTL and testbench

//  Output end of the player interface: drives the 4-digit multiplexed 7-segment display with the score from game_fsm.

---
 rtl/score_display_driver_pkg.sv | 41 ++++
 rtl/score_display_driver_bin2bcd.sv | 65 ++++++
 rtl/score_display_driver.sv | 178 +++++++++++++++++
 tb/tb_score_display_driver.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_driver_pkg.sv
// rtl/score_display_driver_pkg.sv - shared display constants, conversion states and segment encoder
// Contents:
//   NUM_DIGITS   number of multiplexed digits
//   SEG_BLANK    active-low pattern with every segment off
//   AN_OFF       active-low anode pattern with every digit off
//   conv_state_e BCD conversion sequencer states
//   seg_encode   BCD digit -> active-low {g,f,e,d,c,b,a} pattern
package score_display_driver_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_S,
    ST_SHIFT_S,
    ST_LOAD_T,
    ST_SHIFT_T,
    ST_COMMIT
  } conv_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/score_display_driver_bin2bcd.sv
// rtl/score_display_driver_bin2bcd.sv - sequential shift-add-3 binary to 2-digit BCD converter
// Ports:
//   clock, reset  system clock, asynchronous active-low reset
//   start         load bin and begin a conversion of len bits
//   bin           binary value, right-aligned
//   len           number of significant bits in bin (= number of shift cycles)
//   busy          1 while shift cycles remain
//   done          1 during the cycle whose closing edge performs the last shift
//   tens, ones    BCD result, valid once busy has dropped
module score_display_driver_bin2bcd #(
  parameter int W     = 7,
  parameter int LEN_W = $clog2(W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     bin,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  logic [W-1:0]     sh;
  logic [7:0]       bcd;
  logic [7:0]       adj;
  logic [W+7:0]     shifted;
  logic [LEN_W-1:0] cnt;
  logic             busy_q;

  always_comb begin
    adj = bcd;
    if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
  end

  // Results stay below 100, so the bit shifted out of the tens nibble is always 0.
  assign shifted = {adj, sh} << 1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh     <= '0;
      bcd    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      // Left-align so the first shift always moves the value's MSB into the BCD field.
      sh     <= bin << (W - int'(len));
      bcd    <= '0;
      cnt    <= len;
      busy_q <= (len != '0);
    end else if (busy_q) begin
      {bcd, sh} <= shifted;
      cnt       <= cnt - LEN_W'(1);
      if (cnt == LEN_W'(1)) busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt == LEN_W'(1));
  assign tens = bcd[7:4];
  assign ones = bcd[3:0];

endmodule

// File: rtl/score_display_driver.sv
// rtl/score_display_driver.sv - 4-digit multiplexed 7-segment driver showing score and time left
// Ports:
//   clock      system clock
//   reset      asynchronous active-low reset
//   enable     1 = display driven, 0 = all digits blanked (scan and conversion continue)
//   score      binary score
//   time_left  binary seconds remaining, shown saturated at 99
//   an         digit anodes, active-low, an[0] = rightmost
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low, lit on the time ones digit as a separator
//   busy       1 while a BCD conversion is in progress
module score_display_driver
  import score_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int SCORE_W     = 6,
  parameter int TIME_W      = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [SCORE_W-1:0] score,
  input  logic [TIME_W-1:0]  time_left,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               dp,
  output logic               busy
);

  localparam int                CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam int                CONV_W   = (TIME_W > SCORE_W) ? TIME_W : SCORE_W;
  localparam int                LEN_W    = $clog2(CONV_W + 1);
  localparam logic [TIME_W-1:0] TIME_MAX = TIME_W'(99);

  logic [CNT_W-1:0]   scan_cnt;
  logic [1:0]         digit_idx;
  logic               scan_tick;

  conv_state_e        state, state_next;
  logic [SCORE_W-1:0] score_shadow;
  logic [TIME_W-1:0]  time_shadow;
  logic [TIME_W-1:0]  time_sat;
  logic               capture;

  logic               conv_start;
  logic [CONV_W-1:0]  conv_bin;
  logic [LEN_W-1:0]   conv_len;
  logic               conv_busy;
  logic               conv_done;
  logic [3:0]         conv_tens;
  logic [3:0]         conv_ones;

  logic [3:0]         score_tens_tmp;
  logic [3:0]         score_ones_tmp;
  // {time tens, time ones, score tens, score ones}, indexed by digit_idx
  logic [NUM_DIGITS-1:0][3:0] digit_q;
  logic [3:0]         digit_val;
  logic               digit_blank;

  // ---------------- scan ----------------
  assign scan_tick = (scan_cnt == CNT_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_tick) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + CNT_W'(1);
    end
  end

  // ---------------- conversion sequencer ----------------
  assign time_sat = (time_left > TIME_MAX) ? TIME_MAX : time_left;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    conv_start = 1'b0;
    conv_bin   = '0;
    conv_len   = '0;
    case (state)
      ST_IDLE: begin
        if ({time_sat, score} != {time_shadow, score_shadow}) begin
          capture    = 1'b1;
          state_next = ST_LOAD_S;
        end
      end
      ST_LOAD_S: begin
        conv_start = 1'b1;
        conv_bin   = CONV_W'(score_shadow);
        conv_len   = LEN_W'(SCORE_W);
        state_next = ST_SHIFT_S;
      end
      ST_SHIFT_S: if (conv_done) state_next = ST_LOAD_T;
      ST_LOAD_T: begin
        conv_start = 1'b1;
        conv_bin   = CONV_W'(time_shadow);
        conv_len   = LEN_W'(TIME_W);
        state_next = ST_SHIFT_T;
      end
      ST_SHIFT_T: if (conv_done) state_next = ST_COMMIT;
      ST_COMMIT:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  score_display_driver_bin2bcd #(
    .W     (CONV_W),
    .LEN_W (LEN_W)
  ) u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .len   (conv_len),
    .busy  (conv_busy),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  // The score result is parked while the converter is reused for time, and all
  // four digits land together in COMMIT so a scan never shows a half-updated pair.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      score_shadow   <= '0;
      time_shadow    <= '0;
      score_tens_tmp <= '0;
      score_ones_tmp <= '0;
      digit_q        <= '0;
    end else begin
      if (capture) begin
        score_shadow <= score;
        time_shadow  <= time_sat;
      end
      if (state == ST_LOAD_T) begin
        score_tens_tmp <= conv_tens;
        score_ones_tmp <= conv_ones;
      end
      if (state == ST_COMMIT) begin
        digit_q <= {conv_tens, conv_ones, score_tens_tmp, score_ones_tmp};
      end
    end
  end

  assign busy = (state != ST_IDLE) || conv_busy;

  // ---------------- digit mux and output registers ----------------
  assign digit_val   = digit_q[digit_idx];
  // Odd indices are tens digits; a zero there is a leading zero.
  assign digit_blank = digit_idx[0] && (digit_val == 4'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (!enable) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << digit_idx);
      seg <= digit_blank ? SEG_BLANK : seg_encode(digit_val);
      dp  <= (digit_idx != 2'd2);
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
// tb/tb_score_display_driver.sv - self-checking bench for score_display_driver
module tb_score_display_driver;

  localparam int REFRESH_DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [5:0] score = '0;
  logic [6:0] time_left = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  disp_t      exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clock = ~clock;

  score_display_driver #(
    .REFRESH_DIV (REFRESH_DIV),
    .SCORE_W     (6),
    .TIME_W      (7)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .score     (score),
    .time_left (time_left),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .busy      (busy)
  );

  function automatic disp_t model(input int idx, input int sc, input int tm);
    disp_t r;
    int    t;
    int    d;
    t = (tm > 99) ? 99 : tm;
    case (idx)
      0:       d = sc % 10;
      1:       d = sc / 10;
      2:       d = t % 10;
      default: d = t / 10;
    endcase
    r.an      = 4'hF;
    r.an[idx] = 1'b0;
    r.seg     = ((idx == 1 || idx == 3) && d == 0) ? 7'h7F : seg_tab[d];
    r.dp      = (idx == 2) ? 1'b0 : 1'b1;
    return r;
  endfunction

  task automatic push_frame(input int sc, input int tm);
    for (int i = 0; i < 4; i++) exp_q.push_back(model(i, sc, tm));
  endtask

  task automatic wait_an_e(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (an === 4'hE) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 80; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
  endtask

  task automatic current_idx(output int idx);
    logic [3:0] m;
    idx = -1;
    for (int i = 0; i < 4; i++) begin
      m = 4'b0001 << i;
      if (an === ~m) idx = i;
    end
  endtask

  task automatic test_reset();
    disp_t exp;
    bit    found;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL reset_async_outputs: an=%h seg=%h dp=%b required an=f seg=7f dp=1", an, seg, dp);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_busy: busy=%b required 0", busy);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    push_frame(0, 0);
    wait_an_e(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_frame_sync: an=%h required e within 40 cycles", an);
    end
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if ({an, seg, dp} !== exp) begin
        errors++;
        $display("FAIL reset_frame_d%0d: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp.an, exp.seg, exp.dp);
      end
      repeat (REFRESH_DIV) @(negedge clock);
    end
  endtask

  task automatic test_convert();
    disp_t exp;
    bit    found;
    score     = 6'd42;
    time_left = 7'd30;
    for (int j = 0; j <= 16; j++) begin
      @(negedge clock);
      if (j == 0 || j == 15) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL convert_busy_high_j%0d: busy=%b required 1", j, busy);
        end
      end
      if (j == 16) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL convert_busy_low_j16: busy=%b required 0", busy);
        end
      end
    end
    @(negedge clock);
    push_frame(42, 30);
    wait_an_e(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL convert_frame_sync: an=%h required e within 40 cycles", an);
    end
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if ({an, seg, dp} !== exp) begin
        errors++;
        $display("FAIL convert_frame_d%0d: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp.an, exp.seg, exp.dp);
      end
      repeat (REFRESH_DIV) @(negedge clock);
    end
  endtask

  task automatic test_saturate();
    disp_t exp;
    bit    found;
    bit    ok;
    score     = 6'd5;
    time_left = 7'd127;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL saturate_conv_done: busy=%b required 0 within 80 cycles", busy);
    end
    push_frame(5, 127);
    wait_an_e(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL saturate_frame_sync: an=%h required e within 40 cycles", an);
    end
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if ({an, seg, dp} !== exp) begin
        errors++;
        $display("FAIL saturate_frame_d%0d: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp.an, exp.seg, exp.dp);
      end
      repeat (REFRESH_DIV) @(negedge clock);
    end
  endtask

  task automatic test_busy_change();
    disp_t exp;
    bit    found;
    bit    ok;
    int    idx;
    score     = 6'd10;
    time_left = 7'd30;
    for (int j = 0; j <= 29; j++) begin
      @(negedge clock);
      if (j == 2) score = 6'd11;
      if (j == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busychg_busy_start: busy=%b required 1", busy);
        end
      end
      if (j == 16) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busychg_idle_gap: busy=%b required 0", busy);
        end
      end
      if (j == 17 || j == 21 || j == 25 || j == 29) begin
        current_idx(idx);
        exp = (idx < 0) ? disp_t'(0) : model(idx, 10, 30);
        checks++;
        if (idx < 0 || {an, seg, dp} !== exp) begin
          errors++;
          $display("FAIL busychg_old_value_j%0d: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                   j, an, seg, dp, exp.an, exp.seg, exp.dp);
        end
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busychg_second_conv: busy=%b required 0 within 80 cycles", busy);
    end
    push_frame(11, 30);
    wait_an_e(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL busychg_frame_sync: an=%h required e within 40 cycles", an);
    end
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if ({an, seg, dp} !== exp) begin
        errors++;
        $display("FAIL busychg_frame_d%0d: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp.an, exp.seg, exp.dp);
      end
      repeat (REFRESH_DIV) @(negedge clock);
    end
  endtask

  task automatic test_enable();
    disp_t exp;
    bit    found;
    bit    ok;
    int    idx;
    enable = 1'b0;
    score  = 6'd7;
    @(negedge clock);
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL enable_blank: an=%h seg=%h dp=%b required an=f seg=7f dp=1", an, seg, dp);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL enable_conv_runs: busy=%b required 1", busy);
    end
    wait_idle(ok);
    checks++;
    if (!ok || {an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL enable_blank_held: an=%h seg=%h dp=%b busy=%b required an=f seg=7f dp=1 busy=0",
               an, seg, dp, busy);
    end
    enable = 1'b1;
    @(negedge clock);
    current_idx(idx);
    exp = (idx < 0) ? disp_t'(0) : model(idx, 7, 30);
    checks++;
    if (idx < 0 || {an, seg, dp} !== exp) begin
      errors++;
      $display("FAIL enable_resume: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
               an, seg, dp, exp.an, exp.seg, exp.dp);
    end
    push_frame(7, 30);
    wait_an_e(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL enable_frame_sync: an=%h required e within 40 cycles", an);
    end
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if ({an, seg, dp} !== exp) begin
        errors++;
        $display("FAIL enable_frame_d%0d: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp.an, exp.seg, exp.dp);
      end
      repeat (REFRESH_DIV) @(negedge clock);
    end
  endtask

  task automatic test_reset_mid();
    disp_t exp;
    bit    found;
    time_left = 7'd88;
    repeat (11) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_in_shift_t: busy=%b required 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, an, seg, dp} !== {1'b0, 4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_async: busy=%b an=%h seg=%h dp=%b required busy=0 an=f seg=7f dp=1",
               busy, an, seg, dp);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      @(negedge clock);
      if (j == 0) begin
        checks++;
        if ({busy, an, seg, dp} !== {1'b1, 4'hE, 7'h40, 1'b1}) begin
          errors++;
          $display("FAIL rstmid_zero_digit: busy=%b an=%h seg=%h dp=%b required busy=1 an=e seg=40 dp=1",
                   busy, an, seg, dp);
        end
      end
      if (j == 15) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_busy_j15: busy=%b required 1", busy);
        end
      end
      if (j == 16) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_busy_j16: busy=%b required 0", busy);
        end
      end
    end
    @(negedge clock);
    push_frame(7, 88);
    wait_an_e(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_frame_sync: an=%h required e within 40 cycles", an);
    end
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if ({an, seg, dp} !== exp) begin
        errors++;
        $display("FAIL rstmid_frame_d%0d: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp.an, exp.seg, exp.dp);
      end
      repeat (REFRESH_DIV) @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_saturate();
    test_busy_change();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required summary before that", $time);
    $fatal(1);
  end

endmodule
